// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the single-cycle MIPS core.
// Owns the PC. Fetches one word over a req/ack handshake with instruction
// memory and holds it stable for the control decoder. When the datapath
// retires the held instruction, the unit steps the PC to the sequential,
// branch or jump target.
//
// Ports:
//   clk, reset       rising-edge clock; asynchronous active-high reset
//   imem_req         registered fetch request, high for every request cycle
//   imem_addr        fetch address, always equal to pc
//   imem_ack         memory has valid data on imem_rdata this cycle
//   imem_rdata       instruction word from memory
//   instruction      held instruction word (NOP after reset)
//   instr_valid      instruction is valid and held
//   pc               address of the held or requested instruction
//   advance          datapath has retired the held instruction
//   is_jump          decoder: J-format jump (has priority over is_branch)
//   is_branch        decoder: conditional branch
//   branch_taken     branch condition true
//   addr26           jump target field
//   imm16            branch offset field (word offset, sign-extended)
//   fault            sticky timeout: no ack within WAIT_LIMIT request cycles
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  input  logic        advance,
  input  logic        is_jump,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic [25:0] addr26,
  input  logic [15:0] imm16,
  output logic        fault
);

  localparam int unsigned      CNT_W     = 8;
  localparam logic [31:0]      PC_INIT   = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {
    START = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
  logic [31:0]      pc_d, instr_d;
  logic             valid_d, req_d, fault_d;
  logic [31:0]      pc4, br_off, jump_pc, next_pc;

  // Memory always sees the current PC.
  assign imem_addr = pc;

  // Next-PC selection; all sums wrap mod 2^32.
  assign pc4     = pc + 32'd4;
  assign br_off  = {{14{imm16[15]}}, imm16, 2'b00};
  assign jump_pc = {pc4[31:28], addr26, 2'b00};
  always_comb begin
    next_pc = pc4;
    if (is_jump) begin
      next_pc = jump_pc;
    end else if (is_branch && branch_taken) begin
      next_pc = pc4 + br_off;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= START;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; an ack on the last allowed cycle wins over the timeout.
  always_comb begin
    state_d = state;
    case (state)
      START: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          state_d = HOLD;
        end else if (wait_cnt == LAST_WAIT) begin
          state_d = FAULT;
        end
      end
      HOLD: begin
        if (advance) begin
          state_d = REQ;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  // Next values for the registered outputs and the wait counter.
  always_comb begin
    pc_d       = pc;
    instr_d    = instruction;
    valid_d    = instr_valid;
    wait_cnt_d = wait_cnt;
    case (state)
      REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (advance) begin
          pc_d       = next_pc;
          valid_d    = 1'b0;
          wait_cnt_d = '0;
        end
      end
      FAULT:   valid_d = 1'b0;
      default: ;
    endcase
    req_d   = (state_d == REQ);
    fault_d = (state_d == FAULT);
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= PC_INIT;
      instruction <= 32'h0000_0000;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fault       <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      pc          <= pc_d;
      instruction <= instr_d;
      instr_valid <= valid_d;
      imem_req    <= req_d;
      fault       <= fault_d;
      wait_cnt    <= wait_cnt_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage for the single-cycle MIPS core. It sits directly upstream of the control decoder.
- Owns the PC and requests instructions from instruction memory over a req/ack handshake.
- Holds the fetched word stable for decode.
- Computes the next PC from the decoder's is_jump/is_branch outputs plus addr26/imm16 when the datapath signals completion.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] forced to 00.
WAIT_LIMIT, 16, max REQ cycles without imem_ack before fault; legal range 1..255.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address; always equals pc
imem_ack  input  1  memory has valid data on imem_rdata this cycle
imem_rdata  input  32  instruction word from memory
instruction  output  32  held instruction word to control decoder
instr_valid  output  1  instruction is valid and held
pc  output  32  address of the held/requested instruction
advance  input  1  datapath has retired the held instruction
is_jump  input  1  from decoder: J-format jump
is_branch  input  1  from decoder: conditional branch
branch_taken  input  1  branch condition true (from ALU/compare)
addr26  input  26  jump target field from decoder
imm16  input  16  branch offset field from decoder
fault  output  1  sticky fetch timeout

Behaviour:
- Reset (async, immediate), all outputs and state:
  - pc=RESET_PC&~3, instruction=32'h0000_0000 (NOP), instr_valid=0, imem_req=0, fault=0, wait_cnt=0, state=START.
- States: START, REQ, HOLD, FAULT.
- START: one cycle after reset release, then ->REQ.
- REQ:
  - imem_req=1 (registered, high for every REQ cycle); imem_addr=pc combinationally.
  - On a clock edge with imem_ack=1: instruction<=imem_rdata, instr_valid<=1, imem_req<=0, ->HOLD.
  - Without ack: wait_cnt++. When the WAIT_LIMIT-th REQ cycle ends without ack: ->FAULT.
  - Ack on that final cycle wins over fault.
- HOLD:
  - instruction, pc and instr_valid are stable; imem_req=0.
  - On a clock edge with advance=1: pc<=next_pc, instr_valid<=0, wait_cnt<=0, ->REQ.
- FAULT: fault=1, imem_req=0, instr_valid=0. Sticky; only reset exits.
- next_pc, all arithmetic mod 2^32, with pc4=pc+4:
  - is_jump=1: {pc4[31:28], addr26, 2'b00}.
  - else is_branch=1 and branch_taken=1: pc4 + ({{14{imm16[15]}}, imm16, 2'b00}).
  - else: pc4.
  - is_jump has priority over is_branch.
- Ignored inputs:
  - advance is ignored outside HOLD.
  - imem_ack is ignored outside REQ; imem_rdata is only sampled on an accepted ack.
  - is_jump/is_branch/branch_taken/addr26/imm16 are sampled only on the accepted advance edge.
- Latency:
  - advance edge to imem_req high: 1 cycle.
  - Ack on first REQ cycle gives instr_valid high 2 edges after advance. Throughput is 1 instruction per 2 cycles minimum.
  - After reset release: START, then REQ at edge 1; first instr_valid no earlier than edge 2.
- Wrap: pc=32'hFFFF_FFFC sequential gives 32'h0000_0000. Branch/jump targets wrap likewise.
- pc[1:0] is always 00.
- Reset mid-REQ or mid-HOLD: imem_req and instr_valid drop asynchronously; a late ack after reset release lands in START and is ignored.

Test Plan:
- Reset with RESET_PC=32'h0000_0100, memory acks after 0 wait cycles -> imem_addr=0x100 on the first REQ cycle; instr_valid=1 with instruction=memory[0x100]; sequential advances fetch 0x104, 0x108, each instr_valid rising 2 edges after advance.
- Jump at pc=0x1000_0040 with is_jump=1, addr26=26'h0000_010 -> next imem_addr=0x1000_0040. At pc=0x0000_0000 with addr26=26'h3FF_FFFF -> 0x0FFF_FFFC.
- Branch at pc=0x200, imm16=16'hFFFE:
  - taken=1 -> next pc=0x1FC.
  - taken=0 -> 0x204.
  - is_jump=1 and is_branch=1 together -> jump target used.
- pc=0xFFFF_FFFC with advance and no jump/branch -> pc=0x0000_0000, imem_req=1 next cycle.
- Memory never acks, WAIT_LIMIT=4 -> imem_req high exactly 4 cycles then low, fault=1 sticky, instr_valid=0. A later ack has no effect; reset clears fault.
- Ack on exactly the 4th REQ cycle -> no fault, instr_valid=1.
- Assert reset during REQ and during HOLD -> imem_req/instr_valid=0 in the same cycle before any clock edge, pc=RESET_PC. A stray ack in START is ignored; fetch restarts normally.
